// File: rtl/bram_rmw_ctrl_pkg.sv
// Shared definitions for the block-RAM read-modify-write controller:
// FSM state encoding, counter width and the byte-lane merge helper.
package bram_rmw_ctrl_pkg;

  localparam int RMW_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_RESP = 2'd1,
    ST_RMW       = 2'd2,
    ST_WRITE_ACK = 2'd3
  } state_t;

  // Enabled lanes take the new store byte, the rest keep the byte read back from RAM.
  function automatic logic [7:0] merge_byte(input logic       en,
                                            input logic [7:0] wr_byte,
                                            input logic [7:0] rd_byte);
    return en ? wr_byte : rd_byte;
  endfunction

endpackage

// File: rtl/bram_rmw_ctrl.sv
// Request front-end for a simple-dual-port block RAM; partial stores become
// read-modify-write sequences, full-word stores write directly.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | ready for a request; accept cycle issues the RAM strobe
// ST_LOAD_RESP | RAM read data is valid; return it with resp_valid
// ST_RMW       | merge read data with latched store bytes, write back, respond
// ST_WRITE_ACK | full-word or empty store already done; acknowledge it
module bram_rmw_ctrl
  import bram_rmw_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  input  logic [DATA_WIDTH/8-1:0]    req_byte_en,
  output logic                       resp_valid,
  output logic [DATA_WIDTH-1:0]      resp_rdata,
  output logic                       bram_read_enable,
  output logic [ADDR_WIDTH-1:0]      bram_read_address,
  input  logic [DATA_WIDTH-1:0]      bram_read_data,
  output logic                       bram_write_enable,
  output logic [ADDR_WIDTH-1:0]      bram_write_address,
  output logic [DATA_WIDTH-1:0]      bram_write_data,
  output logic [RMW_COUNT_WIDTH-1:0] rmw_count
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  state_t                     state;
  state_t                     state_next;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [BE_WIDTH-1:0]        be_q;
  logic                       write_q;
  logic [RMW_COUNT_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0]      merged;
  logic                       accept;
  logic                       be_full;
  logic                       be_none;

  assign accept  = req_valid && (state == ST_IDLE) && !reset;
  assign be_full = &req_byte_en;
  assign be_none = ~|req_byte_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_byte_en;
      write_q <= req_write;
    end
  end

  // Counter saturates instead of wrapping so a long soak still reads as "many".
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (state == ST_RMW && count_q != '1) begin
      count_q <= count_q + RMW_COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!req_write)            state_next = ST_LOAD_RESP;
          else if (be_full || be_none) state_next = ST_WRITE_ACK;
          else                       state_next = ST_RMW;
        end
      end
      ST_LOAD_RESP: state_next = ST_IDLE;
      ST_RMW:       state_next = ST_IDLE;
      ST_WRITE_ACK: state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    merged = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      merged[8*i +: 8] = merge_byte(be_q[i], wdata_q[8*i +: 8], bram_read_data[8*i +: 8]);
    end
  end

  always_comb begin
    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    resp_rdata         = '0;
    bram_read_enable   = 1'b0;
    bram_read_address  = '0;
    bram_write_enable  = 1'b0;
    bram_write_address = '0;
    bram_write_data    = '0;
    rmw_count          = '0;
    if (!reset) begin
      rmw_count = count_q;
      case (state)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (accept) begin
            if (!req_write || (!be_full && !be_none)) begin
              bram_read_enable  = 1'b1;
              bram_read_address = req_addr;
            end else if (be_full) begin
              bram_write_enable  = 1'b1;
              bram_write_address = req_addr;
              bram_write_data    = req_wdata;
            end
          end
        end
        ST_LOAD_RESP: begin
          resp_valid = 1'b1;
          resp_rdata = write_q ? '0 : bram_read_data;
        end
        ST_RMW: begin
          resp_valid         = 1'b1;
          bram_write_enable  = 1'b1;
          bram_write_address = addr_q;
          bram_write_data    = merged;
        end
        ST_WRITE_ACK: begin
          resp_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_rmw_ctrl.sv
// Self-checking bench for bram_rmw_ctrl: a behavioural block RAM plus a
// word-level reference memory that predicts every strobe and response.
module tb_bram_rmw_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_en;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        bram_read_enable;
  logic [7:0]  bram_read_address;
  logic [31:0] bram_read_data;
  logic        bram_write_enable;
  logic [7:0]  bram_write_address;
  logic [31:0] bram_write_data;
  logic [15:0] rmw_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_rmw_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bram_read_enable(bram_read_enable), .bram_read_address(bram_read_address),
    .bram_read_data(bram_read_data),
    .bram_write_enable(bram_write_enable), .bram_write_address(bram_write_address),
    .bram_write_data(bram_write_data), .rmw_count(rmw_count)
  );

  // Block RAM with one-cycle read latency and a backdoor preload port.
  logic [31:0] mem [256];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  always @(posedge clk) begin
    if (bram_read_enable) bram_read_data <= mem[bram_read_address];
    if (bram_write_enable) mem[bram_write_address] <= bram_write_data;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  int          ref_count = 0;

  typedef struct packed {
    logic        rdy0;
    logic        re0;
    logic [7:0]  ra0;
    logic        we0;
    logic [7:0]  wa0;
    logic [31:0] wd0;
    logic        rv0;
    logic [31:0] rd0;
    logic        rdy1;
    logic        re1;
    logic        we1;
    logic [7:0]  wa1;
    logic [31:0] wd1;
    logic        rv1;
    logic [31:0] rd1;
  } obs_t;

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Predicts accept-cycle and response-cycle behaviour from the request alone.
  task automatic model_op(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, output obs_t e);
    logic [31:0] m;
    e = '0;
    e.rdy0 = 1'b1;
    e.rv1  = 1'b1;
    if (!w) begin
      e.re0 = 1'b1; e.ra0 = a;
      e.rd1 = ref_mem[a];
    end else if (be == 4'hF) begin
      e.we0 = 1'b1; e.wa0 = a; e.wd0 = d;
      ref_mem[a] = d;
    end else if (be != 4'h0) begin
      m = ref_mem[a];
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
      e.re0 = 1'b1; e.ra0 = a;
      e.we1 = 1'b1; e.wa1 = a; e.wd1 = m;
      ref_mem[a] = m;
      if (ref_count < 16'hFFFF) ref_count++;
    end
  endtask

  function automatic obs_t sample_now();
    obs_t o;
    o = '0;
    o.rdy0 = req_ready;
    o.re0  = bram_read_enable;
    o.ra0  = bram_read_enable ? bram_read_address : 8'h0;
    o.we0  = bram_write_enable;
    o.wa0  = bram_write_enable ? bram_write_address : 8'h0;
    o.wd0  = bram_write_enable ? bram_write_data : 32'h0;
    o.rv0  = resp_valid;
    o.rd0  = resp_rdata;
    return o;
  endfunction

  // Drives one request starting just after a rising edge; returns two cycles of observation.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, output obs_t o);
    obs_t s;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_byte_en = be;
    @(negedge clk);
    o = sample_now();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom; req_byte_en = 4'($urandom);
    @(negedge clk);
    s = sample_now();
    o.rdy1 = s.rdy0; o.re1 = s.re0; o.we1 = s.we0; o.wa1 = s.wa0;
    o.wd1 = s.wd0; o.rv1 = s.rv0; o.rd1 = s.rd0;
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] pick_be();
    case ($urandom % 4)
      0: return 4'h0;
      1: return 4'hF;
      default: return 4'($urandom_range(1, 14));
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10;
    req_wdata = 32'hFFFF_FFFF; req_byte_en = 4'hF;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, bram_read_enable, bram_write_enable} !== 4'b0 ||
        resp_rdata !== 32'h0 || rmw_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rv=%b re=%b we=%b rdata=%h cnt=%h, want all 0",
               req_ready, resp_valid, bram_read_enable, bram_write_enable, resp_rdata, rmw_count);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i <= 32; i++) preload(8'(i), $urandom);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rmw_count !== 16'h0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b cnt=%h rv=%b, want ready=1 cnt=0 rv=0",
               req_ready, rmw_count, resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    obs_t e, o;
    preload(8'h10, 32'h1122_3344);
    model_op(1'b0, 8'h10, 32'h0, 4'h0, e);
    issue(1'b0, 8'h10, 32'h0, 4'h0, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL load_seq: got %h want %h", o, e);
    end
    checks++;
    if (o.rd1 !== 32'h1122_3344) begin
      failures++;
      $display("FAIL load_data: got %h want 11223344", o.rd1);
    end
  endtask

  task automatic test_full_store();
    obs_t e, o;
    model_op(1'b1, 8'h10, 32'hAABB_CCDD, 4'hF, e);
    issue(1'b1, 8'h10, 32'hAABB_CCDD, 4'hF, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL full_store_seq: got %h want %h", o, e);
    end
    model_op(1'b0, 8'h10, 32'h0, 4'h0, e);
    issue(1'b0, 8'h10, 32'h0, 4'h0, o);
    checks++;
    if (o.rd1 !== 32'hAABB_CCDD || o.rv1 !== 1'b1) begin
      failures++;
      $display("FAIL full_store_reload: got rv=%b data=%h want rv=1 data=aabbccdd", o.rv1, o.rd1);
    end
  endtask

  task automatic test_partial_store();
    obs_t e, o;
    preload(8'h10, 32'h1122_3344);
    checks++;
    if (rmw_count !== 16'd0) begin
      failures++;
      $display("FAIL rmw_count_before: got %0d want 0", rmw_count);
    end
    model_op(1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101, e);
    issue(1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL partial_store_seq: got %h want %h", o, e);
    end
    checks++;
    if (o.wd1 !== 32'h11BB_33DD || mem[8'h10] !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL partial_store_merge: wdata=%h mem=%h want 11bb33dd", o.wd1, mem[8'h10]);
    end
    checks++;
    if (rmw_count !== 16'd1) begin
      failures++;
      $display("FAIL rmw_count_after: got %0d want 1", rmw_count);
    end
  endtask

  task automatic test_zero_store();
    obs_t e, o;
    model_op(1'b1, 8'h10, 32'h5A5A_5A5A, 4'h0, e);
    issue(1'b1, 8'h10, 32'h5A5A_5A5A, 4'h0, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL zero_store_seq: got %h want %h", o, e);
    end
    checks++;
    if (mem[8'h10] !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL zero_store_mem: got %h want 11bb33dd", mem[8'h10]);
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    logic w;
    logic [7:0] a;
    logic [31:0] d;
    logic [3:0] be;
    int bad;
    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom); a = 8'($urandom_range(0, 31)); d = $urandom; be = pick_be();
      model_op(w, a, d, be, e);
      issue(w, a, d, be, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random_op_%0d: w=%b a=%h be=%b got %h want %h", n, w, a, be, o, e);
      end
    end
    checks++;
    if (rmw_count !== 16'(ref_count)) begin
      failures++;
      $display("FAIL random_rmw_count: got %0d want %0d", rmw_count, ref_count);
    end
    bad = 0;
    for (int i = 0; i <= 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL random_mem_sweep: %0d words differ, want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic pending;
    int accepts, resps;
    pending = 1'b0; accepts = 0; resps = 0; e = '0;
    req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      req_write = 1'($urandom); req_addr = 8'($urandom_range(0, 31));
      req_wdata = $urandom; req_byte_en = pick_be();
      @(negedge clk);
      checks++;
      if (req_ready !== !pending || resp_valid !== pending) begin
        failures++;
        $display("FAIL b2b_handshake_%0d: ready=%b rv=%b want ready=%b rv=%b",
                 k, req_ready, resp_valid, !pending, pending);
      end
      if (resp_valid === 1'b1) resps++;
      if (pending) begin
        checks++;
        if (resp_rdata !== e.rd1 || bram_write_enable !== e.we1 ||
            (e.we1 && (bram_write_address !== e.wa1 || bram_write_data !== e.wd1))) begin
          failures++;
          $display("FAIL b2b_resp_%0d: rdata=%h we=%b wa=%h wd=%h want rdata=%h we=%b wa=%h wd=%h",
                   k, resp_rdata, bram_write_enable, bram_write_address, bram_write_data,
                   e.rd1, e.we1, e.wa1, e.wd1);
        end
        pending = 1'b0;
      end else begin
        model_op(req_write, req_addr, req_wdata, req_byte_en, e);
        accepts++;
        pending = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (resp_valid === 1'b1) resps++;
    @(posedge clk); #1;
    checks++;
    if (resps != accepts || accepts != 10) begin
      failures++;
      $display("FAIL b2b_resp_count: resps=%0d accepts=%0d want 10 each", resps, accepts);
    end
  endtask

  task automatic test_reset_in_rmw();
    obs_t e, o;
    preload(8'h20, 32'h5566_7788);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20;
    req_wdata = 32'hDEAD_BEEF; req_byte_en = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || bram_read_enable !== 1'b1 || bram_read_address !== 8'h20) begin
      failures++;
      $display("FAIL rmw_reset_accept: ready=%b re=%b ra=%h want 1 1 20",
               req_ready, bram_read_enable, bram_read_address);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bram_write_enable !== 1'b0 || resp_valid !== 1'b0 || rmw_count !== 16'h0) begin
      failures++;
      $display("FAIL rmw_reset_suppress: we=%b rv=%b cnt=%h want 0 0 0",
               bram_write_enable, resp_valid, rmw_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ref_count = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || bram_write_enable !== 1'b0 ||
        rmw_count !== 16'h0) begin
      failures++;
      $display("FAIL rmw_reset_idle: ready=%b rv=%b we=%b cnt=%h want 1 0 0 0",
               req_ready, resp_valid, bram_write_enable, rmw_count);
    end
    @(posedge clk); #1;
    checks++;
    if (mem[8'h20] !== 32'h5566_7788) begin
      failures++;
      $display("FAIL rmw_reset_word: got %h want 55667788", mem[8'h20]);
    end
    model_op(1'b1, 8'h20, 32'h0000_00AB, 4'b0001, e);
    issue(1'b1, 8'h20, 32'h0000_00AB, 4'b0001, o);
    checks++;
    if (o !== e || rmw_count !== 16'd1 || mem[8'h20] !== 32'h5566_77AB) begin
      failures++;
      $display("FAIL rmw_after_reset: cnt=%0d mem=%h want cnt=1 mem=556677ab (seq got %h want %h)",
               rmw_count, mem[8'h20], o, e);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_byte_en = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_full_store();
    test_partial_store();
    test_zero_store();
    test_random();
    test_back_to_back();
    test_reset_in_rmw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
